// File: rtl/lift_ibuff_collect_if.sv
// lift_ibuff_collect_if
// Bundles the residue stream coming from the BRAM address generator and the
// parallel group handshake going to the lift datapath.
//   lift_mode, in_valid, in_last, in_data : residue stream into the collector
//   in_ready                              : a bank is free, a new group may start
//   out_valid, out_ready                  : group handshake towards the datapath
//   out_mode, out_q, out_p                : presented group (slot 0 in the low bits)
//   err                                   : sticky protocol-error flag
// The producer/consumer side of the bench uses "master", the collector uses "slave".
interface lift_ibuff_collect_if #(
    parameter int W = 30
);
    logic             lift_mode;
    logic             in_valid;
    logic             in_last;
    logic [W-1:0]     in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic             out_mode;
    logic [6*W-1:0]   out_q;
    logic [7*W-1:0]   out_p;
    logic             err;

    modport master (
        output lift_mode, in_valid, in_last, in_data, out_ready,
        input  in_ready, out_valid, out_mode, out_q, out_p, err
    );

    modport slave (
        input  lift_mode, in_valid, in_last, in_data, out_ready,
        output in_ready, out_valid, out_mode, out_q, out_p, err
    );
endinterface

// File: rtl/lift_ibuff_collect.sv
// lift_ibuff_collect
// Collects residues streamed one word per cycle into two ping-pong banks of
// 13 words each and presents every completed group in parallel.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : lift_ibuff_collect_if.slave (stream in, group handshake out, err)
// All outputs are registers loaded from next-state values, so a group whose
// last word is accepted on edge N is presented in the cycle after edge N.
module lift_ibuff_collect #(
    parameter int W = 30
) (
    input  logic                  clk,
    input  logic                  rst,
    lift_ibuff_collect_if.slave   bus
);

    localparam int NSLOT = 13;

    // Storage and control state.
    logic [W-1:0]     bank_r [2][NSLOT];
    logic [1:0]       full_r;
    logic [1:0]       mode_r;
    logic             wp_r;
    logic             rp_r;
    logic [3:0]       cnt_r;
    logic             err_r;

    // Output registers.
    logic             in_ready_r;
    logic             out_valid_r;
    logic             out_mode_r;
    logic [6*W-1:0]   out_q_r;
    logic [7*W-1:0]   out_p_r;

    // Next-state / decode signals.
    logic             accept_s;
    logic             overflow_s;
    logic             big_s;
    logic [3:0]       last_idx_s;
    logic             at_end_s;
    logic             complete_s;
    logic             len_err_s;
    logic             consume_s;
    logic             clear_p_s;
    logic             hit_s;
    logic [1:0]       full_n_s;
    logic             wp_n_s;
    logic             rp_n_s;
    logic [3:0]       cnt_n_s;
    logic             err_n_s;
    logic [W-1:0]     sel_s [NSLOT];
    logic             sel_mode_s;
    logic [6*W-1:0]   out_q_n_s;
    logic [7*W-1:0]   out_p_n_s;

    // Decode the current word, derive next state and the group that will be
    // presented after this edge.
    always_comb begin
        accept_s   = bus.in_valid & ~full_r[wp_r];
        overflow_s = bus.in_valid &  full_r[wp_r];
        // Group size is taken from lift_mode only on the first word; later
        // words use the mode already latched for the bank being filled.
        big_s      = (cnt_r == 4'd0) ? bus.lift_mode : mode_r[wp_r];
        last_idx_s = big_s ? 4'd12 : 4'd5;
        at_end_s   = (cnt_r == last_idx_s);
        complete_s = accept_s & bus.in_last & at_end_s;
        len_err_s  = accept_s & (bus.in_last ^ at_end_s);
        consume_s  = full_r[rp_r] & bus.out_ready;
        clear_p_s  = complete_s & ~big_s;

        // Completion and consumption always target different banks.
        full_n_s[0] = (complete_s && (wp_r == 1'b0)) ? 1'b1 :
                      ((consume_s && (rp_r == 1'b0)) ? 1'b0 : full_r[0]);
        full_n_s[1] = (complete_s && (wp_r == 1'b1)) ? 1'b1 :
                      ((consume_s && (rp_r == 1'b1)) ? 1'b0 : full_r[1]);
        wp_n_s      = complete_s ? ~wp_r : wp_r;
        rp_n_s      = consume_s  ? ~rp_r : rp_r;

        if (accept_s) begin
            cnt_n_s = (complete_s | len_err_s) ? 4'd0 : (cnt_r + 4'd1);
        end else begin
            cnt_n_s = cnt_r;
        end

        err_n_s = err_r | overflow_s | len_err_s;

        // The bank presented next may be the one written on this edge, so the
        // incoming word and the small-group p clear are forwarded here.
        hit_s = (rp_n_s == wp_r);
        for (int i = 0; i < NSLOT; i++) begin
            sel_s[i] = (hit_s && clear_p_s && (i >= 6)) ? {W{1'b0}} :
                       ((hit_s && accept_s && (cnt_r == 4'(i))) ? bus.in_data :
                        bank_r[rp_n_s][i]);
        end
        sel_mode_s = (hit_s && accept_s && (cnt_r == 4'd0)) ? bus.lift_mode :
                     mode_r[rp_n_s];

        out_q_n_s = {6*W{1'b0}};
        out_p_n_s = {7*W{1'b0}};
        for (int i = 0; i < 6; i++) begin
            out_q_n_s[i*W +: W] = sel_s[i];
        end
        for (int j = 0; j < 7; j++) begin
            out_p_n_s[j*W +: W] = sel_s[j+6];
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NSLOT; i++) begin
                    bank_r[b][i] <= {W{1'b0}};
                end
            end
            full_r      <= 2'b00;
            mode_r      <= 2'b00;
            wp_r        <= 1'b0;
            rp_r        <= 1'b0;
            cnt_r       <= 4'd0;
            err_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_mode_r  <= 1'b0;
            out_q_r     <= {6*W{1'b0}};
            out_p_r     <= {7*W{1'b0}};
        end else begin
            // Slot index equals the word count: q slots 0..5, p slots 6..12.
            if (accept_s) begin
                bank_r[wp_r][cnt_r] <= bus.in_data;
            end
            if (clear_p_s) begin
                for (int i = 6; i < NSLOT; i++) begin
                    bank_r[wp_r][i] <= {W{1'b0}};
                end
            end
            if (accept_s && (cnt_r == 4'd0)) begin
                mode_r[wp_r] <= bus.lift_mode;
            end
            full_r      <= full_n_s;
            wp_r        <= wp_n_s;
            rp_r        <= rp_n_s;
            cnt_r       <= cnt_n_s;
            err_r       <= err_n_s;
            in_ready_r  <= ~(full_n_s[0] & full_n_s[1]);
            out_valid_r <= full_n_s[rp_n_s];
            out_mode_r  <= sel_mode_s;
            out_q_r     <= out_q_n_s;
            out_p_r     <= out_p_n_s;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_mode  = out_mode_r;
    assign bus.out_q     = out_q_r;
    assign bus.out_p     = out_p_r;
    assign bus.err       = err_r;

endmodule

// File: doc/lift_ibuff_collect.md
# lift_ibuff_collect

Receive-side companion of the lift-shoup BRAM address generator. The generator streams residues out of the coefficient BRAMs one word per cycle, slot by slot. This block collects each coefficient's residues into one of two ping-pong banks. It then presents each complete group in parallel to the lift datapath through a valid/ready handshake, and signals back whether a new group may be started.

## Interface
- W, 30, residue word width in bits
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- lift_mode  in  1  0 small (6-word group), 1 big (13-word group: 6 q-shares then 7 p-shares); sampled on the first word of each group
- in_valid  in  1  in_data carries a residue this cycle (BRAM output, already delayed by read latency)
- in_last  in  1  qualifies in_valid; marks the final word of the group
- in_data  in  W  residue word
- in_ready  out  1  registered; 1 = at least one bank free, upstream may start a new group
- out_valid  out  1  registered; oldest full bank presented
- out_ready  in  1  lift datapath consumes the presented group when out_valid & out_ready
- out_mode  out  1  lift_mode captured with the presented group
- out_q  out  6*W  q-share words, slot 0 in bits [W-1:0]
- out_p  out  7*W  p-share words, slot 0 in bits [W-1:0]; zero for small-mode groups
- err  out  1  sticky protocol-error flag, cleared only by rst

## Operation
- Two banks B0/B1, each 13 x W registers plus a full flag and a captured mode bit. A write pointer (wp) and a read pointer (rp) are each 1 bit.
- Word counter cnt, 4 bits. Group size GS = 6 (small) or 13 (big), latched on the accepted word with cnt==0.
- Accepted word: in_valid while bank[wp] is not full. Word k<6 goes to q-slot k; word k>=6 goes to p-slot k-6.
- Group completion: an accepted word with in_last=1 and cnt==GS-1 sets full[wp], toggles wp, and resets cnt to 0.
- Length error: in_last=1 with cnt!=GS-1, or cnt==GS-1 with in_last=0. Either one sets err, discards the partial group (bank not marked full, cnt to 0), and leaves wp unchanged.
- Overflow: in_valid while bank[wp] is full sets err. The word is dropped and cnt is unchanged.
- Bank slots of a small group at p-positions are cleared to 0 when the group completes.
- Read side: out_valid = full[rp]. out_q, out_p and out_mode come from bank[rp]. On out_valid & out_ready, full[rp] clears and rp toggles.
- in_ready = !(full[0] & full[1]), from next-state values, so it reflects completions and consumptions of the same edge.
- Banks retire strictly in fill order.
- Mode change is legal only at cnt==0. A lift_mode change mid-group is ignored until the next group.

## Timing
- Reset values: in_ready=1, out_valid=0, out_mode=0, out_q=0, out_p=0, err=0, wp=rp=0, cnt=0, both full flags 0, bank contents 0.
- Latency: last word accepted at edge N gives out_valid=1 after edge N (visible in cycle N+1).
- Throughput: one word per cycle with no bubbles required between groups while in_ready=1.
- Simultaneous completion and consumption on the same edge:
  - Both actions are applied.
  - With one bank full and the other completing, out_valid stays 1 and switches to the other bank.
  - in_ready stays 1.
- When both banks are full, in_ready=0 from the edge after the completion.
- Upstream must hold off new groups while in_ready=0. A group already started when in_ready falls is not possible, because in_ready falls only at completion.
- out_ready while out_valid=0 has no effect.
- rst mid-group or with banks full returns every signal to its reset value on that edge. The partial group is lost and no err is raised.

## Test plan
- Small group, words 1..6 with in_last on the 6th, out_ready=1 -> out_valid one cycle later; out_q = {6,5,4,3,2,1}; out_p=0; out_mode=0; consumed; in_ready stays 1.
- Big group, words 0x10..0x1C back-to-back -> out_q slots 0..5 = 0x10..0x15; out_p slots 0..6 = 0x16..0x1C; out_mode=1.
- Three small groups with out_ready=0 -> in_ready=0 after the second group. The third group's first word sets err, and banks 0/1 are unaffected. Raising out_ready then releases the first group before the second.
- Small group with in_last on the 4th word -> err=1, no out_valid. A following correct 6-word group is delivered normally.
- One bank full and presented, second group completing on the same edge as out_ready=1 -> out_valid stays high with the second group next cycle; in_ready=1 throughout.
- rst asserted after 3 words of a big group -> all outputs at reset values next cycle. A subsequent small group is delivered and err stays 0.
